// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counting timer. A reload value is accepted over
//               a valid/ready handshake while the timer is IDLE or DONE. A start
//               pulse begins counting down from the reload value. At zero a
//               one-cycle done pulse is produced and the timer either reloads
//               (LOOP = 1) or parks in DONE (LOOP = 0). i_ctrl toggles
//               pause/resume and i_abort returns to IDLE.
// Ports       :
//   i_clk         clock, rising-edge active
//   i_rst         asynchronous active-high reset
//   i_load_valid  load request
//   i_load_val    reload value (clamped to MAX_CNT)
//   o_load_ready  high in IDLE or DONE (load accepted)
//   i_start       start pulse (IDLE/DONE only)
//   i_ctrl        pause/resume toggle pulse (RUN/PAUSE only)
//   i_abort       return to IDLE, count cleared, reload value kept
//   o_cnt_val     current count (registered)
//   o_cnt_done    one-cycle terminal-count pulse (registered)
//   o_busy        high in RUN or PAUSE
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
  parameter int MAX_CNT = 255,
  parameter bit LOOP    = 1'b1,
  localparam int CNT_W  = $clog2(MAX_CNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_valid,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_load_ready,
  input  logic             i_start,
  input  logic             i_ctrl,
  input  logic             i_abort,
  output logic [CNT_W-1:0] o_cnt_val,
  output logic             o_cnt_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             w_load_fire;
  logic [CNT_W-1:0] w_load_clamped;

  // When MAX_CNT fills the whole count width no input can exceed it, so the
  // comparator is dropped rather than left as a constant-false compare.
  if (MAX_CNT == (1 << CNT_W) - 1) begin : g_no_clamp
    assign w_load_clamped = i_load_val;
  end else begin : g_clamp
    assign w_load_clamped = (i_load_val > C_MAX) ? C_MAX : i_load_val;
  end

  assign o_load_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign o_busy       = (state_q == S_RUN)  || (state_q == S_PAUSE);
  assign w_load_fire  = i_load_valid && o_load_ready;

  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    if (i_abort) begin
      // Abort wins over everything, including a load at the same edge.
      state_d = S_IDLE;
      cnt_d   = C_ZERO;
    end else begin
      if (w_load_fire) begin
        reload_d = w_load_clamped;
        cnt_d    = w_load_clamped;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_d = S_RUN;
            // A load at the start edge supplies the starting count; otherwise
            // restart from the reload register, not the residual count.
            cnt_d   = w_load_fire ? w_load_clamped : reload_q;
          end
        end

        S_RUN: begin
          if (i_ctrl) begin
            // Pausing edge holds the count, even at zero (no done pulse).
            state_d = S_PAUSE;
          end else if (cnt_q != C_ZERO) begin
            cnt_d = cnt_q - C_ONE;
          end else begin
            done_d = 1'b1;
            if (LOOP) begin
              cnt_d = reload_q;
            end else begin
              state_d = S_DONE;
              cnt_d   = C_ZERO;
            end
          end
        end

        S_PAUSE: begin
          // Resume edge does not decrement either.
          if (i_ctrl) begin
            state_d = S_RUN;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      reload_q <= C_ZERO;
      cnt_q    <= C_ZERO;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign o_cnt_val  = cnt_q;
  assign o_cnt_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Self-checking bench for countdown_timer. Three instances share
//               one stimulus: one-shot (LOOP=0, MAX 255), looping (LOOP=1,
//               MAX 255) and a clamping one-shot (LOOP=0, MAX 200).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, lv, ctrl, abort;
  logic [7:0] val;

  logic [7:0] s_cnt, l_cnt, c_cnt;
  logic       s_done, s_busy, s_rdy;
  logic       l_done, l_busy, l_rdy;
  logic       c_done, c_busy, c_rdy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer #(.MAX_CNT(255), .LOOP(1'b0)) dut_s (
    .i_clk(clk), .i_rst(rst), .i_load_valid(lv), .i_load_val(val),
    .o_load_ready(s_rdy), .i_start(start), .i_ctrl(ctrl), .i_abort(abort),
    .o_cnt_val(s_cnt), .o_cnt_done(s_done), .o_busy(s_busy)
  );

  countdown_timer #(.MAX_CNT(255), .LOOP(1'b1)) dut_l (
    .i_clk(clk), .i_rst(rst), .i_load_valid(lv), .i_load_val(val),
    .o_load_ready(l_rdy), .i_start(start), .i_ctrl(ctrl), .i_abort(abort),
    .o_cnt_val(l_cnt), .o_cnt_done(l_done), .o_busy(l_busy)
  );

  countdown_timer #(.MAX_CNT(200), .LOOP(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_load_valid(lv), .i_load_val(val),
    .o_load_ready(c_rdy), .i_start(start), .i_ctrl(ctrl), .i_abort(abort),
    .o_cnt_val(c_cnt), .o_cnt_done(c_done), .o_busy(c_busy)
  );

  typedef struct {
    logic       st;
    logic       lv;
    logic [7:0] val;
    logic       ctrl;
    logic       ab;
    logic [7:0] cnt;
    logic       done;
    logic       busy;
    logic       rdy;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs set just after an edge are sampled at the next edge; outputs are
  // read 1 ns after that edge.
  task automatic tick(input logic st, input logic l, input logic [7:0] v,
                      input logic c, input logic a);
    start = st; lv = l; val = v; ctrl = c; abort = a;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    start = 1'b0; lv = 1'b0; val = 8'd0; ctrl = 1'b0; abort = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // One-shot instance: load 5, count out, restart, ignored loads/starts,
    // pause/resume and abort.
    //            st    lv    val    ctrl  ab    cnt    done  busy  rdy
    tbl[0]  = '{1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1};

    // Reset values on every instance.
    rst = 1'b1;
    start = 1'b0; lv = 1'b0; val = 8'd0; ctrl = 1'b0; abort = 1'b0;
    #3;
    chk("reset s_cnt", s_cnt, 0);
    chk("reset s_done", s_done, 0);
    chk("reset s_busy", s_busy, 0);
    chk("reset s_rdy", s_rdy, 1);
    chk("reset l_cnt", l_cnt, 0);
    chk("reset c_cnt", c_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      tick(tbl[i].st, tbl[i].lv, tbl[i].val, tbl[i].ctrl, tbl[i].ab);
      chk($sformatf("vec%0d cnt", i), s_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d done", i), s_done, tbl[i].done);
      chk($sformatf("vec%0d busy", i), s_busy, tbl[i].busy);
      chk($sformatf("vec%0d rdy", i), s_rdy, tbl[i].rdy);
    end

    // LOOP=1, reload 3: period of 4, count reads 3 on each pulse cycle.
    do_reset();
    tick(1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("loop start cnt", l_cnt, 3);
    for (int k = 1; k <= 20; k++) begin
      idle();
      chk($sformatf("loop k%0d done", k), l_done, ((k % 4) == 0) ? 1 : 0);
      chk($sformatf("loop k%0d cnt", k), l_cnt, ((k % 4) == 0) ? 3 : 3 - (k % 4));
      chk($sformatf("loop k%0d busy", k), l_busy, 1);
    end

    // Pause at count 2 for 5 cycles: done 6 edges later than unpaused (E11).
    do_reset();
    tick(1'b0, 1'b1, 8'd4, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);          // E0
    idle();                                        // E1
    idle();                                        // E2
    chk("pause pre cnt", s_cnt, 2);
    tick(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);          // E3 pause
    chk("pause edge cnt", s_cnt, 2);
    for (int k = 4; k <= 7; k++) begin
      tick(1'b0, 1'b1, 8'd9, 1'b0, 1'b0);        // loads ignored in PAUSE
      chk($sformatf("pause hold E%0d cnt", k), s_cnt, 2);
      chk($sformatf("pause hold E%0d busy", k), s_busy, 1);
      chk($sformatf("pause hold E%0d rdy", k), s_rdy, 0);
    end
    tick(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);          // E8 resume
    chk("resume edge cnt", s_cnt, 2);
    idle();                                        // E9
    chk("pause E9 cnt", s_cnt, 1);
    idle();                                        // E10
    chk("pause E10 cnt", s_cnt, 0);
    chk("pause E10 done", s_done, 0);
    idle();                                        // E11
    chk("pause E11 done", s_done, 1);
    chk("pause E11 busy", s_busy, 0);
    idle();
    chk("pause after done", s_done, 0);

    // Clamping on the MAX_CNT=200 instance.
    do_reset();
    tick(1'b0, 1'b1, 8'd250, 1'b0, 1'b0);
    chk("clamp 250", c_cnt, 200);
    chk("noclamp 250 on 255", s_cnt, 250);
    tick(1'b0, 1'b1, 8'd201, 1'b0, 1'b0);
    chk("clamp 201", c_cnt, 200);
    tick(1'b0, 1'b1, 8'd200, 1'b0, 1'b0);
    chk("clamp 200", c_cnt, 200);
    tick(1'b0, 1'b1, 8'd255, 1'b0, 1'b0);
    chk("max load 255", s_cnt, 255);
    chk("clamp 255", c_cnt, 200);
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("clamp start", c_cnt, 200);
    tick(1'b0, 1'b1, 8'd7, 1'b0, 1'b0);
    chk("clamp run load ignored", c_cnt, 199);
    idle();
    chk("clamp run continues", c_cnt, 198);

    // Asynchronous reset mid-count, then start with reload = 0.
    do_reset();
    tick(1'b0, 1'b1, 8'd5, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk("prerst cnt", s_cnt, 3);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst s_cnt", s_cnt, 0);
    chk("async rst s_busy", s_busy, 0);
    chk("async rst s_rdy", s_rdy, 1);
    chk("async rst l_cnt", l_cnt, 0);
    chk("async rst l_done", l_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("zero start s_cnt", s_cnt, 0);
    chk("zero start s_busy", s_busy, 1);
    chk("zero start l_done", l_done, 0);
    idle();
    chk("zero s_done", s_done, 1);
    chk("zero s_busy", s_busy, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("zero loop done %0d", k), l_done, 1);
      chk($sformatf("zero loop busy %0d", k), l_busy, 1);
      idle();
    end
    chk("zero s_done after", s_done, 0);

    // Start + load at the same edge, then pause while the count is zero.
    do_reset();
    tick(1'b1, 1'b1, 8'd7, 1'b0, 1'b0);
    chk("start+load cnt", s_cnt, 7);
    chk("start+load busy", s_busy, 1);
    for (int k = 0; k < 7; k++) idle();
    chk("reach zero cnt", s_cnt, 0);
    chk("reach zero done", s_done, 0);
    tick(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("ctrl at zero done", s_done, 0);
    chk("ctrl at zero busy", s_busy, 1);
    idle();
    chk("zero paused done", s_done, 0);
    tick(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("zero resume done", s_done, 0);
    chk("zero resume cnt", s_cnt, 0);
    idle();
    chk("zero resume pulse", s_done, 1);
    chk("zero resume state", s_rdy, 1);
    tick(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("restart from reload 7", s_cnt, 7);
    chk("restart pulse cleared", s_done, 0);
    tick(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("final abort cnt", s_cnt, 0);
    chk("final abort busy", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
